// File: rtl/rv32i_seq_ctrl_if.sv
// Memory-side bus of the RV32I control sequencer.
// The master modport is the sequencer; the slave modport is the memory system.
interface rv32i_seq_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH, DECODE, EXEC, MEM, WB.
// Define SEQ_TRAP_EN to add the TRAP state for illegal opcodes.
module rv32i_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic                    clk,
    input  logic                    rst,
    rv32i_seq_ctrl_if.master        bus,
    output logic [31:0]             instr,
    output logic [31:0]             pc,
    input  logic [31:0]             target,
    input  logic                    branch_taken,
    output logic                    rf_we,
    output logic                    retire,
    output logic                    trap
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef SEQ_TRAP_EN
    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;
`endif

    state_t      state;
    logic        fetch_req;
    logic        data_req;
    logic        data_we;

    logic [6:0]  opcode;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_wr;
    logic        is_legal;
    logic        is_mem;
    logic        wb_we;

    logic [31:0] pc_seq;
    logic [31:0] pc_jump;
    logic [31:0] pc_next;

    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = data_req;
    assign bus.dmem_we   = data_we;

    // Classify the latched instruction by its major opcode.
    always_comb begin
        opcode    = instr[6:0];
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_wr     = 1'b0;
        is_legal  = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                is_wr    = 1'b1;
                is_legal = 1'b1;
            end
            OP_LOAD: begin
                is_load  = 1'b1;
                is_wr    = 1'b1;
                is_legal = 1'b1;
            end
            OP_STORE: begin
                is_store = 1'b1;
                is_legal = 1'b1;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                is_legal  = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                is_jump  = 1'b1;
                is_wr    = 1'b1;
                is_legal = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                is_legal = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
            end
        endcase
    end

    assign is_mem = is_load | is_store;
    assign wb_we  = is_wr & (instr[11:7] != 5'd0);

    // Next PC: word-aligned target for jumps and taken branches, else pc+4.
    always_comb begin
        pc_seq  = pc + 32'd4;
        pc_jump = {target[31:2], 2'b00};
        pc_next = pc_seq;
        if (is_jump || (is_branch && branch_taken)) begin
            pc_next = pc_jump;
        end
    end

`ifdef SEQ_TRAP_EN
    logic trap_pulse;
    assign trap = trap_pulse;
`else
    assign trap = 1'b0;
    logic unused_cfg;
    assign unused_cfg = &{1'b0, TRAP_VEC, is_legal};
`endif

    logic unused_tgt;
    assign unused_tgt = &{1'b0, target[1:0]};

    // Sequencer: state plus registered, state-decoded strobes and PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= NOP_WORD;
            fetch_req <= 1'b0;
            data_req  <= 1'b0;
            data_we   <= 1'b0;
            rf_we     <= 1'b0;
            retire    <= 1'b0;
`ifdef SEQ_TRAP_EN
            trap_pulse <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_req && bus.imem_ready) begin
                        instr     <= bus.imem_rdata;
                        fetch_req <= 1'b0;
                        state     <= ST_DECODE;
                    end else begin
                        fetch_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_mem) begin
                        data_req <= 1'b1;
                        data_we  <= is_store;
                        state    <= ST_MEM;
`ifdef SEQ_TRAP_EN
                    end else if (!is_legal) begin
                        trap_pulse <= 1'b1;
                        state      <= ST_TRAP;
`endif
                    end else begin
                        retire <= 1'b1;
                        rf_we  <= wb_we;
                        state  <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        data_req <= 1'b0;
                        data_we  <= 1'b0;
                        retire   <= 1'b1;
                        rf_we    <= wb_we;
                        state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    retire    <= 1'b0;
                    rf_we     <= 1'b0;
                    pc        <= pc_next;
                    fetch_req <= 1'b1;
                    state     <= ST_FETCH;
                end
`ifdef SEQ_TRAP_EN
                ST_TRAP: begin
                    trap_pulse <= 1'b0;
                    pc         <= TRAP_VEC;
                    fetch_req  <= 1'b1;
                    state      <= ST_FETCH;
                end
`endif
                default: begin
                    fetch_req <= 1'b0;
                    data_req  <= 1'b0;
                    data_we   <= 1'b0;
                    rf_we     <= 1'b0;
                    retire    <= 1'b0;
                    state     <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Bench for rv32i_seq_ctrl: directed instructions, scoreboarded retire events.
// Expected completions are queued by stimulus and checked by a monitor.
module tb_rv32i_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TV     = 32'h0000_0010;

    typedef struct {
        int          cyc;
        logic        we;
        logic        trp;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] target;
    logic        branch_taken;
    logic        rf_we;
    logic        retire;
    logic        trap;

    rv32i_seq_ctrl_if bus ();

    rv32i_seq_ctrl #(
        .RESET_PC (RST_PC),
        .TRAP_VEC (TV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .instr        (instr),
        .pc           (pc),
        .target       (target),
        .branch_taken (branch_taken),
        .rf_we        (rf_we),
        .retire       (retire),
        .trap         (trap)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q[$];
    logic        pend = 1'b0;
    logic [31:0] pend_pc = '0;
    logic [31:0] model_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation on every retire/trap pulse.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk("next_pc", pc, pend_pc);
            pend = 1'b0;
        end
        if (retire || trap) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {30'd0, retire, trap}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                chk("trap", {31'd0, trap}, {31'd0, e.trp});
                chk("retire", {31'd0, retire}, {31'd0, ~e.trp});
                chk("done_pc", pc, e.pc);
                pend    = 1'b1;
                pend_pc = e.npc;
            end
        end
    end

    task automatic wait_fetch();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    endtask

    // One instruction: fetch with iw wait cycles, dw data wait cycles.
    task automatic run(input logic [31:0] word, input int iw, input int dw,
                       input logic tk, input logic [31:0] tgt,
                       input logic mem, input logic st, input logic we,
                       input logic trp, input logic [31:0] npc);
        int   n;
        int   hi;
        exp_t e;
        wait_fetch();
        e.cyc = cyc + 3 + iw + (mem ? 1 + dw : 0);
        e.we  = we;
        e.trp = trp;
        e.pc  = model_pc;
        e.npc = npc;
        q.push_back(e);
        branch_taken = tk;
        target       = tgt;
        for (int i = 0; i < iw; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            chk("fetch_addr", bus.imem_addr, model_pc);
            chk("fetch_hold", {31'd0, bus.imem_req}, 32'd1);
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        chk("fetch_addr", bus.imem_addr, model_pc);
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hFFFF_FFFF;
        chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
        chk("instr", instr, word);
        if (mem) begin
            n = 0;
            while (!bus.dmem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            hi = 0;
            for (int i = 0; i < dw; i++) begin
                bus.dmem_ready = 1'b0;
                if (bus.dmem_req) hi++;
                @(negedge clk);
            end
            chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, st});
            bus.dmem_ready = 1'b1;
            if (bus.dmem_req) hi++;
            @(negedge clk);
            bus.dmem_ready = 1'b0;
            chk("dmem_req_cycles", hi, dw + 1);
            chk("dmem_drop", {31'd0, bus.dmem_req}, 32'd0);
        end
        model_pc = npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst            = 1'b1;
        target         = '0;
        branch_taken   = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        model_pc       = RST_PC;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_strobes",
            {26'd0, bus.imem_req, bus.dmem_req, bus.dmem_we,
             rf_we, retire, trap}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cycle1_req", {31'd0, bus.imem_req}, 32'd1);
        chk("cycle1_addr", bus.imem_addr, 32'h0);

        // addi x1,x0,5
        run(32'h0050_0093, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4);
        // add x0,x0,x0 with 3 fetch wait cycles
        run(32'h0000_0033, 3, 0, 0, 0, 0, 0, 0, 0, 32'h8);
`ifdef SEQ_TRAP_EN
        run(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, TV);
`else
        run(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC);
`endif
        // beq taken to 0x40, then not taken
        run(32'h0000_0463, 0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40);
        run(32'h0000_0463, 0, 0, 0, 32'h80, 0, 0, 0, 0, 32'h44);
        // lw x2 with 2 data wait cycles, then sw
        run(32'h0000_A103, 0, 2, 0, 0, 1, 0, 1, 0, 32'h48);
        run(32'h0020_A023, 0, 0, 0, 0, 1, 1, 0, 0, 32'h4C);
        // lui x1 and ecall (NOP)
        run(32'h1234_50B7, 0, 0, 0, 0, 0, 0, 1, 0, 32'h50);
        run(32'h0000_0073, 1, 0, 0, 0, 0, 0, 0, 0, 32'h54);
        // jal x1 with misaligned target 0x23 -> 0x20
        run(32'h0000_00EF, 0, 0, 0, 32'h23, 0, 0, 1, 0, 32'h20);

        // lw at 0x20, reset during the data wait
        wait_fetch();
        chk("mid_addr", bus.imem_addr, 32'h20);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_A103;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        n = 0;
        while (!bus.dmem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_dreq", {31'd0, bus.dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dreq", {31'd0, bus.dmem_req}, 32'd0);
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_out", {29'd0, rf_we, retire, trap}, 32'd0);
        rst      = 1'b0;
        model_pc = RST_PC;

        // jalr to 0xFFFFFFFC, fence wraps to 0
        run(32'h0000_8067, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'hFFFF_FFFC);
        run(32'h0000_000F, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        // back to 0xFFFFFFFC, jal with target 0x103 -> 0x100
        run(32'h0000_8067, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC);
        run(32'h0000_00EF, 0, 0, 0, 32'h103, 0, 0, 1, 0, 32'h100);

        n = 0;
        while ((q.size() != 0 || pend) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_seq_ctrl.md
# rv32i_seq_ctrl

Multi-cycle control sequencer for the RV32I core. It fetches each instruction over a request/ready instruction-memory port and holds it stable for the combinational decoder. It then steps the datapath through DECODE, EXEC, optional MEM and WB, and drives the register-file write strobe and data-memory handshake. It owns the program counter, updating it from the sequential path, jump targets and taken branches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_VEC`, default 32'h0000_0010: PC loaded on an illegal-instruction trap. Used only with `SEQ_TRAP_EN`.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: instruction fetch request.
- `imem_addr`  out  32: fetch address; always equals `pc`.
- `imem_ready`  in  1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `instr`  out  32: latched instruction, fed to the decoder.
- `pc`  out  32: address of the current instruction.
- `target`  in  32: jump/branch target computed by the datapath.
- `branch_taken`  in  1: branch compare result, sampled in WB.
- `dmem_req`  out  1: data memory request.
- `dmem_we`  out  1: 1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_ready`  in  1: data access complete.
- `rf_we`  out  1: register-file write strobe, 1-cycle pulse.
- `retire`  out  1: instruction-complete pulse.
- `trap`  out  1: illegal-instruction pulse. Tied to 0 without `SEQ_TRAP_EN`.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The TRAP state exists only with `SEQ_TRAP_EN`.
- Opcode classification uses `instr[6:0]`:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - FENCE 0001111 and SYSTEM 1110011 execute as NOPs.
  - Every other opcode is illegal.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`=1: `instr`<=`imem_rdata`, go to DECODE.
  - Otherwise stay in FETCH with `imem_addr` held stable.
- DECODE: one cycle for decoder outputs to settle, then EXEC.
- EXEC: one cycle.
  - LOAD or STORE -> MEM.
  - Illegal -> TRAP if `SEQ_TRAP_EN` is defined, otherwise WB.
  - Everything else -> WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE, 0 for LOAD.
  - Wait for `dmem_ready`=1, then go to WB.
- WB (one cycle, then FETCH):
  - `retire`=1.
  - `rf_we`=1 iff the opcode is R, I, LOAD, JAL, JALR, LUI or AUIPC and `instr[11:7]`!=0.
  - Next PC: JAL/JALR -> `{target[31:2],2'b00}`; BRANCH with `branch_taken`=1 -> `{target[31:2],2'b00}`; otherwise `pc`+4.
  - `pc`+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- TRAP: `trap`=1 for one cycle, `pc`<=`TRAP_VEC`, no `rf_we`, no `retire`, then FETCH.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.

## Timing
- Reset values:
  - State FETCH, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP).
  - `imem_req`, `dmem_req`, `dmem_we`, `rf_we`, `retire` and `trap` all 0.
- First cycle after `rst` falls: FETCH, `imem_req`=1.
- Request and strobe outputs are registered and state-decoded. `imem_req` falls in the cycle after `imem_ready` is sampled high; `dmem_req` falls in the cycle after `dmem_ready` is sampled high.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle on either port adds 1 cycle.
- Issue interval equals latency; instructions never overlap.
- `pc` changes only on the edge leaving WB or TRAP.
- `rst` mid-operation (any state) takes effect at the next edge: pending requests drop, all outputs return to their reset values, and the in-flight instruction is discarded without `rf_we` or `retire`.

## Configuration
- `SEQ_TRAP_EN`:
  - Defined: illegal opcodes enter TRAP: `trap` pulses and `pc`<=`TRAP_VEC`.
  - Undefined: no TRAP state; illegal opcodes retire as NOPs (`pc`+4, `retire`=1, `rf_we`=0), and `trap` is constant 0.

## Test plan
- Reset, then `imem_ready`=1 and `imem_rdata`=0x00500093 (addi x1,x0,5): `imem_addr`=0 in cycle 1; `rf_we`=`retire`=1 in cycle 4; `pc`=4 in cycle 5.
- `imem_ready` held low for 3 cycles on 0x00000033 (add x0,x0,x0): `imem_addr` stable and `imem_req` high for 4 cycles; `retire` in cycle 7 with `rf_we`=0 (rd=x0).
- BEQ 0x00000463 with `branch_taken`=1 and `target`=0x40: `pc`=0x40, `rf_we`=0. The same BEQ with `branch_taken`=0: `pc`=`pc`+4.
- LW 0x0000A103 with `dmem_ready` after 2 wait cycles: `dmem_req` high 3 cycles with `dmem_we`=0; `rf_we` in WB; total 7 cycles. SW 0x0020A023: `dmem_we`=1, `rf_we`=0.
- Illegal word 0xFFFFFFFF at `pc`=8: with `SEQ_TRAP_EN`, `trap` pulses in cycle 4 and `pc`=0x10; without it, `retire` pulses and `pc`=0xC.
- `rst` asserted during a MEM wait at `pc`=0x20: next cycle `dmem_req`=0, `pc`=`RESET_PC`, no `rf_we` or `retire`. Separately, JAL with `target`=0x103 at `pc`=0xFFFF_FFFC gives `pc`=0x100.
